// File: rtl/decod_rr_arbiter.sv
// ============================================================================
// Module   : decod_rr_arbiter
// Brief    : 16-way round-robin arbiter with hold timeout and one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decod_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_req,
  input  logic        i_done,
  output logic        o_grant_valid,
  output logic [3:0]  o_grant_idx,
  output logic [15:0] o_grant_oh,
  output logic        o_timeout,
  output logic        o_busy
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_GRANT   = 2'd1;
  localparam logic [1:0] c_RECOVER = 2'd2;

  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [15:0]      c_ONE       = 16'h0001;

  logic [1:0]       r_state;
  logic [3:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_grant_valid;
  logic [3:0]       r_grant_idx;
  logic [15:0]      r_grant_oh;
  logic             r_timeout;
  logic             r_busy;

  logic [31:0] w_req_dbl;
  logic [15:0] w_rot;
  logic [3:0]  w_off;
  logic [3:0]  w_winner;
  logic        w_holder_req;

  // Rotate requests so that bit 0 is the requester at ptr; the lowest set
  // bit then gives the round-robin offset from ptr.
  assign w_req_dbl = {i_req, i_req} >> r_ptr;
  assign w_rot     = w_req_dbl[15:0];

  always_comb begin
    w_off = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (w_rot[k]) w_off = 4'(k);
    end
  end

  assign w_winner     = r_ptr + w_off;
  assign w_holder_req = i_req[r_grant_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_IDLE;
      r_ptr         <= 4'd0;
      r_hold_cnt    <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= 4'd0;
      r_grant_oh    <= 16'd0;
      r_timeout     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (i_req != 16'd0) begin
            r_state       <= c_GRANT;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_winner;
            r_grant_oh    <= c_ONE << w_winner;
            r_hold_cnt    <= '0;
            r_busy        <= 1'b1;
          end
        end
        c_GRANT: begin
          if (i_done || !w_holder_req || (r_hold_cnt == c_HOLD_LAST)) begin
            // done and request drop take precedence over the timeout flag
            r_timeout     <= !i_done && w_holder_req;
            r_state       <= c_RECOVER;
            r_ptr         <= r_grant_idx + 4'd1;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= 4'd0;
            r_grant_oh    <= 16'd0;
            r_hold_cnt    <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        c_RECOVER: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state       <= c_IDLE;
          r_grant_valid <= 1'b0;
          r_grant_idx   <= 4'd0;
          r_grant_oh    <= 16'd0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant_valid = r_grant_valid;
  assign o_grant_idx   = r_grant_idx;
  assign o_grant_oh    = r_grant_oh;
  assign o_timeout     = r_timeout;
  assign o_busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_decod_rr_arbiter.sv
// ============================================================================
// Module   : tb_decod_rr_arbiter
// Brief    : Directed self-checking bench for decod_rr_arbiter (MAX_HOLD=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decod_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_oh;
  logic        timeout;
  logic        busy;

  int n_checks;
  int n_fail;

  decod_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .i_req         (req),
    .i_done        (done),
    .o_grant_valid (grant_valid),
    .o_grant_idx   (grant_idx),
    .o_grant_oh    (grant_oh),
    .o_timeout     (timeout),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [3:0] idx,
                         input logic [15:0] oh, input logic to, input logic bz);
    chk({tag, ".valid"},   32'(grant_valid), 32'(v));
    chk({tag, ".idx"},     32'(grant_idx),   32'(idx));
    chk({tag, ".oh"},      32'(grant_oh),    32'(oh));
    chk({tag, ".timeout"}, 32'(timeout),     32'(to));
    chk({tag, ".busy"},    32'(busy),        32'(bz));
  endtask

  // Release the current holder with done, pass RECOVER and IDLE, land on the next grant.
  task automatic release_and_regrant(input string tag, input logic [3:0] exp_idx);
    done = 1'b1;
    tick();
    chk_all({tag, ".rel"}, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    done = 1'b0;
    tick();
    chk_all({tag, ".idle"}, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    tick();
    chk_all({tag, ".gnt"}, 1'b1, exp_idx, 16'h0001 << exp_idx, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    req  = 16'hFFFF;
    done = 1'b0;

    // Reset held for three cycles with every requester active
    tick(); tick(); tick();
    chk_all("reset", 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("first_grant", 1'b1, 4'd0, 16'h0001, 1'b0, 1'b1);

    // Full rotation 1..15 then back to 0
    for (int i = 1; i <= 16; i++) begin
      release_and_regrant($sformatf("rot%0d", i), 4'(i % 16));
    end

    // Service 13 so ptr becomes 14, then wrap to 0 and skip to 4
    req = 16'h2000;
    release_and_regrant("svc13", 4'd13);
    req = 16'h0011;
    release_and_regrant("wrap0", 4'd0);
    release_and_regrant("skip4", 4'd4);

    // Sole requester 5 held without done: 8 grant cycles then timeout
    req = 16'h0020;
    release_and_regrant("to_start", 4'd5);
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk_all($sformatf("to_hold%0d", c), 1'b1, 4'd5, 16'h0020, 1'b0, 1'b1);
    end
    tick();
    chk_all("to_pulse", 1'b0, 4'd0, 16'd0, 1'b1, 1'b1);
    tick();
    chk_all("to_dead", 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    tick();
    chk_all("to_regrant", 1'b1, 4'd5, 16'h0020, 1'b0, 1'b1);

    // done in the last allowed grant cycle wins over timeout
    for (int c = 2; c <= 8; c++) tick();
    chk_all("col_last", 1'b1, 4'd5, 16'h0020, 1'b0, 1'b1);
    done = 1'b1;
    tick();
    chk_all("col_rel", 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    done = 1'b0;
    tick();
    tick();
    chk_all("col_regrant", 1'b1, 4'd5, 16'h0020, 1'b0, 1'b1);

    // Holder drops its request mid-grant
    tick();
    req = 16'h0000;
    tick();
    chk_all("drop_rel", 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);

    // Reset on the third grant cycle of requester 9
    req = 16'h0200;
    tick();
    chk_all("r9_idle", 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    tick();
    chk_all("r9_gnt1", 1'b1, 4'd9, 16'h0200, 1'b0, 1'b1);
    tick(); tick();
    chk_all("r9_gnt3", 1'b1, 4'd9, 16'h0200, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    chk_all("r9_reset", 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("r9_regrant", 1'b1, 4'd9, 16'h0200, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
